// File: rtl/sram_controller_if.sv
// Bundle between the Mem stage / board SRAM pins and the SRAM controller.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit Mem-stage access into two WAIT_CYCLES-long halfword accesses on a 16-bit async SRAM.
// state | meaning:  IDLE | waiting for request,  LOW | halfword {word,0},  HIGH | halfword {word,1},  DONE | one-cycle completion
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input logic                clk,
    input logic                rst,
    sram_controller_if.slave   bus
);
    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t             r_state, w_nxt_state;
    logic [CW-1:0]      r_cnt, w_nxt_cnt;
    logic               r_is_write;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;

    logic               w_req;
    logic               w_last;
    logic [31:0]        w_diff;
    logic [SRAM_AW-2:0] w_in_word;
    logic               w_is_write;
    logic [SRAM_AW-2:0] w_word;
    logic [31:0]        w_wdata;
    logic [SRAM_AW-1:0] w_nxt_addr;
    logic [15:0]        w_nxt_dq_out;
    logic               w_nxt_dq_oe;
    logic               w_nxt_ce_n;
    logic               w_nxt_oe_n;
    logic               w_nxt_we_n;

    assign w_req     = bus.wr_en | bus.rd_en;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_diff    = bus.address - 32'(BASE_ADDR);
    assign w_in_word = (SRAM_AW-1)'(w_diff >> 2);

    // In IDLE the request is being accepted this cycle, so the SRAM pins for the
    // first LOW cycle must be computed from the live inputs rather than the latches.
    assign w_is_write = (r_state == S_IDLE) ? bus.wr_en      : r_is_write;
    assign w_word     = (r_state == S_IDLE) ? w_in_word      : r_word;
    assign w_wdata    = (r_state == S_IDLE) ? bus.write_data : r_wdata;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_nxt_state = S_LOW;
                    w_nxt_cnt   = '0;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_nxt_state = S_HIGH;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Pin values for the upcoming cycle; registered so the SRAM never sees decode glitches.
    always_comb begin
        w_nxt_addr   = r_sram_addr;
        w_nxt_dq_out = r_dq_out;
        w_nxt_dq_oe  = 1'b0;
        w_nxt_ce_n   = 1'b1;
        w_nxt_oe_n   = 1'b1;
        w_nxt_we_n   = 1'b1;
        if ((w_nxt_state == S_LOW) || (w_nxt_state == S_HIGH)) begin
            w_nxt_addr = {w_word, (w_nxt_state == S_HIGH)};
            w_nxt_ce_n = 1'b0;
            if (w_is_write) begin
                w_nxt_dq_oe  = 1'b1;
                w_nxt_dq_out = (w_nxt_state == S_HIGH) ? w_wdata[31:16] : w_wdata[15:0];
                w_nxt_we_n   = (w_nxt_cnt == LAST_CNT);
            end else begin
                w_nxt_oe_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_sram_addr <= w_nxt_addr;
            r_dq_out    <= w_nxt_dq_out;
            r_dq_oe     <= w_nxt_dq_oe;
            r_ce_n      <= w_nxt_ce_n;
            r_oe_n      <= w_nxt_oe_n;
            r_we_n      <= w_nxt_we_n;
            if ((r_state == S_IDLE) && w_req) begin
                r_is_write <= bus.wr_en;
                r_word     <= w_in_word;
                r_wdata    <= bus.write_data;
            end
            if (w_last && !r_is_write) begin
                if (r_state == S_LOW)  r_read_data[15:0]  <= bus.sram_dq_in;
                if (r_state == S_HIGH) r_read_data[31:16] <= bus.sram_dq_in;
            end
        end
    end

    assign bus.ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
    assign bus.read_data   = r_read_data;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_we_n   = r_we_n;
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: default-timing controller plus a WAIT_CYCLES=2 instance, each with a small SRAM model.
module tb_sram_controller;
    logic        clk;
    logic        rst;
    logic        sel;
    logic        tb_wr_en, tb_rd_en;
    logic [31:0] tb_addr, tb_wdata;
    int          n_checks;
    int          n_errors;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];

    sram_controller_if #(.SRAM_AW(18)) ifa ();
    sram_controller_if #(.SRAM_AW(18)) ifb ();

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.wr_en      = tb_wr_en & ~sel;
    assign ifa.rd_en      = tb_rd_en & ~sel;
    assign ifa.address    = tb_addr;
    assign ifa.write_data = tb_wdata;
    assign ifa.sram_dq_in = mem_a[ifa.sram_addr[3:0]];
    assign ifb.wr_en      = tb_wr_en & sel;
    assign ifb.rd_en      = tb_rd_en & sel;
    assign ifb.address    = tb_addr;
    assign ifb.write_data = tb_wdata;
    assign ifb.sram_dq_in = mem_b[ifb.sram_addr[3:0]];

    logic        m_ready, m_we_n, m_ce_n, m_dq_oe;
    logic [17:0] m_addr;
    logic [31:0] m_read_data;
    assign m_ready     = sel ? ifb.ready     : ifa.ready;
    assign m_we_n      = sel ? ifb.sram_we_n : ifa.sram_we_n;
    assign m_ce_n      = sel ? ifb.sram_ce_n : ifa.sram_ce_n;
    assign m_dq_oe     = sel ? ifb.sram_dq_oe : ifa.sram_dq_oe;
    assign m_addr      = sel ? ifb.sram_addr : ifa.sram_addr;
    assign m_read_data = sel ? ifb.read_data : ifa.read_data;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
    end

    // Async SRAM commits on the rising edge of WE while selected.
    always @(posedge ifa.sram_we_n) if (!ifa.sram_ce_n) mem_a[ifa.sram_addr[3:0]] = ifa.sram_dq_out;
    always @(posedge ifb.sram_we_n) if (!ifb.sram_ce_n) mem_b[ifb.sram_addr[3:0]] = ifb.sram_dq_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                          output int rdy_low, output int we_low,
                          output logic [17:0] a_lo, output logic [17:0] a_hi);
        @(negedge clk);
        tb_wr_en = we;
        tb_rd_en = re;
        tb_addr  = a;
        tb_wdata = d;
        #1;
        rdy_low = 0;
        we_low  = 0;
        a_lo    = '0;
        a_hi    = '0;
        for (int i = 0; i < 100; i++) begin
            if (m_ready) break;
            rdy_low++;
            @(negedge clk);
            if (!m_we_n) we_low++;
            if (i == 0) a_lo = m_addr;
            if (!m_ce_n) a_hi = m_addr;
        end
    endtask

    int          rl, wl, cnt;
    logic [17:0] alo, ahi;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        sel = 1'b0;
        tb_wr_en = 1'b0;
        tb_rd_en = 1'b0;
        tb_addr  = 32'h0;
        tb_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, m_ready}, 32'h1);
        check("rst_ce_n", {31'b0, m_ce_n}, 32'h1);
        check("rst_read_data", m_read_data, 32'h0);
        rst = 1'b1;

        // Reset in the middle of a write's LOW phase
        @(negedge clk);
        tb_wr_en = 1'b1; tb_addr = 32'd1024; tb_wdata = 32'hA5A55A5A;
        @(negedge clk);
        check("t1_low_we_n", {31'b0, m_we_n}, 32'h0);
        check("t1_low_dq_oe", {31'b0, m_dq_oe}, 32'h1);
        tb_wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1_abort_we_n", {31'b0, m_we_n}, 32'h1);
        check("t1_abort_dq_oe", {31'b0, m_dq_oe}, 32'h0);
        check("t1_abort_ready", {31'b0, m_ready}, 32'h1);
        check("t1_abort_addr", {14'b0, m_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1_idle_ce_n", {31'b0, m_ce_n}, 32'h1);

        // Word write
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, rl, wl, alo, ahi);
        tb_wr_en = 1'b0;
        check("t2_ready_low", rl, 11);
        check("t2_we_low", wl, 8);
        check("t2_mem0", {16'b0, mem_a[0]}, 32'hBEEF);
        check("t2_mem1", {16'b0, mem_a[1]}, 32'hDEAD);
        @(negedge clk);
        check("t2_idle_ready", {31'b0, m_ready}, 32'h1);

        // Word read back
        access(1'b0, 1'b1, 32'd1024, 32'h0, rl, wl, alo, ahi);
        tb_rd_en = 1'b0;
        check("t3_ready_low", rl, 11);
        check("t3_read_data", m_read_data, 32'hDEADBEEF);
        check("t3_addr_lo", {14'b0, alo}, 32'h0);
        check("t3_addr_hi", {14'b0, ahi}, 32'h1);
        check("t3_we_low", wl, 0);

        // Read request held through DONE must not restart directly from DONE
        access(1'b0, 1'b1, 32'd1024, 32'h0, rl, wl, alo, ahi);
        check("t4_read_data", m_read_data, 32'hDEADBEEF);
        @(negedge clk);
        check("t4_after_done_ready", {31'b0, m_ready}, 32'h0);
        check("t4_after_done_ce_n", {31'b0, m_ce_n}, 32'h1);
        @(negedge clk);
        check("t4_restart_ce_n", {31'b0, m_ce_n}, 32'h0);
        tb_rd_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_ready) break;
            @(negedge clk);
            cnt++;
        end
        check("t4_second_wait", cnt, 10);

        // Both enables high: write wins, read_data untouched
        access(1'b1, 1'b1, 32'd1028, 32'h12345678, rl, wl, alo, ahi);
        tb_wr_en = 1'b0;
        tb_rd_en = 1'b0;
        check("t5_mem2", {16'b0, mem_a[2]}, 32'h5678);
        check("t5_mem3", {16'b0, mem_a[3]}, 32'h1234);
        check("t5_read_data", m_read_data, 32'hDEADBEEF);
        check("t5_we_low", wl, 8);
        check("t5_addr_hi", {14'b0, ahi}, 32'h3);

        // WAIT_CYCLES=2 instance, back-to-back writes
        @(negedge clk);
        sel = 1'b1;
        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, rl, wl, alo, ahi);
        tb_wr_en = 1'b0;
        check("t6a_ready_low", rl, 5);
        check("t6a_we_low", wl, 2);
        check("t6a_mem4", {16'b0, mem_b[4]}, 32'hF00D);
        check("t6a_mem5", {16'b0, mem_b[5]}, 32'hCAFE);
        access(1'b1, 1'b0, 32'd1036, 32'h0BADC0DE, rl, wl, alo, ahi);
        tb_wr_en = 1'b0;
        check("t6b_ready_low", rl, 5);
        check("t6b_we_low", wl, 2);
        check("t6b_addr_lo", {14'b0, alo}, 32'h6);
        check("t6b_addr_hi", {14'b0, ahi}, 32'h7);
        check("t6b_mem6", {16'b0, mem_b[6]}, 32'hC0DE);
        check("t6b_mem7", {16'b0, mem_b[7]}, 32'h0BAD);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
